// File: rtl/sdram_device_responder.sv
// Device-side responder for a 32-bit SDR SDRAM pin interface: decodes commands, tracks banks/timers, serves an internal word array.
// Latency: WRITE commits on its command edge; READ at edge T drives dq with dq_oe=1 from edge T+CAS-1 to edge T+CAS (CAS 2 or 3).
// Backpressure: none; a command is accepted every cycle, illegal commands are dropped and flagged via protocol_err/err_code.
//
// Ports: clk/reset (sync, active-high); sdram_cke, sdram_csn, sdram_rasn, sdram_casn, sdram_wen, sdram_ba,
// sdram_addr, sdram_dqm, sdram_dq_i from the controller; sdram_dq_o/sdram_dq_oe read data back;
// mode_valid (MRS accepted), protocol_err (sticky), err_code (first violation code).
module sdram_device_responder #(
    parameter int MEM_AW   = 12,
    parameter int TRP_CYC  = 2,
    parameter int TRCD_CYC = 2,
    parameter int TRC_CYC  = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sdram_cke,
    input  logic        sdram_csn,
    input  logic        sdram_rasn,
    input  logic        sdram_casn,
    input  logic        sdram_wen,
    input  logic [1:0]  sdram_ba,
    input  logic [10:0] sdram_addr,
    input  logic [3:0]  sdram_dqm,
    input  logic [31:0] sdram_dq_i,
    output logic [31:0] sdram_dq_o,
    output logic        sdram_dq_oe,
    output logic        mode_valid,
    output logic        protocol_err,
    output logic [3:0]  err_code
);
    typedef enum logic [2:0] {
        CMD_MRS   = 3'b000,
        CMD_REF   = 3'b001,
        CMD_PRE   = 3'b010,
        CMD_ACT   = 3'b011,
        CMD_WRITE = 3'b100,
        CMD_READ  = 3'b101,
        CMD_BST   = 3'b110,
        CMD_NOP   = 3'b111
    } cmd_t;

    typedef enum logic {
        BANK_IDLE   = 1'b0,
        BANK_ACTIVE = 1'b1
    } bank_st_t;

    typedef struct packed {
        logic        vld;
        logic [31:0] dat;
    } rd_slot_t;

    localparam logic [3:0] TRP_INIT  = 4'(TRP_CYC);
    localparam logic [3:0] TRCD_INIT = 4'(TRCD_CYC);
    localparam logic [3:0] TRC_INIT  = 4'(TRC_CYC);

    bank_st_t    bank_st  [4];
    logic [10:0] bank_row [4];
    logic [3:0]  trcd_cnt [4];
    logic [3:0]  trp_cnt  [4];
    logic [3:0]  trc_cnt;
    logic        cas3;
    rd_slot_t    rd_pipe  [2];
    logic [31:0] mem      [1 << MEM_AW];

    logic        cmd_en;
    cmd_t        cmd;
    logic        any_active;
    logic        any_trp;
    logic        trc_busy;
    logic        mrs_bad;
    logic [3:0]  rw_code;
    logic [3:0]  viol;
    logic        rd_fire;
    logic        wr_fire;
    logic [20:0] full_addr;
    logic [MEM_AW-1:0] mem_idx;
    logic [31:0] mem_word;
    logic [31:0] rd_word;
    rd_slot_t    rd_out;

    assign cmd_en   = sdram_cke & ~sdram_csn;
    assign cmd      = cmd_t'({sdram_rasn, sdram_casn, sdram_wen});
    assign trc_busy = (trc_cnt != 4'd0);
    assign mrs_bad  = !(sdram_addr[6:4] == 3'd2 || sdram_addr[6:4] == 3'd3) || (sdram_addr[2:0] != 3'd0);

    always_comb begin
        any_active = 1'b0;
        any_trp    = 1'b0;
        for (int b = 0; b < 4; b++) begin
            any_active = any_active | (bank_st[b] == BANK_ACTIVE);
            any_trp    = any_trp | (trp_cnt[b] != 4'd0);
        end
    end

    // READ/WRITE access checks form a chain: only the first failing one is a violation.
    always_comb begin
        if (!mode_valid)                         rw_code = 4'd7;
        else if (bank_st[sdram_ba] == BANK_IDLE) rw_code = 4'd2;
        else if (trcd_cnt[sdram_ba] != 4'd0)     rw_code = 4'd3;
        else                                     rw_code = 4'd0;
    end

    // Each branch lists its candidate violations lowest code first, so the first hit wins.
    always_comb begin
        viol = 4'd0;
        if (cmd_en) begin
            case (cmd)
                CMD_MRS: begin
                    if (trc_busy)        viol = 4'd5;
                    else if (mrs_bad)    viol = 4'd6;
                    else if (any_active) viol = 4'd8;
                end
                CMD_ACT: begin
                    if (bank_st[sdram_ba] == BANK_ACTIVE) viol = 4'd1;
                    else if (trp_cnt[sdram_ba] != 4'd0)   viol = 4'd4;
                    else if (trc_busy)                    viol = 4'd5;
                end
                CMD_READ, CMD_WRITE: begin
                    if (rw_code == 4'd2 || rw_code == 4'd3)      viol = rw_code;
                    else if (trc_busy)                           viol = 4'd5;
                    else if (rw_code != 4'd0)                    viol = rw_code;
                    else if (cmd == CMD_WRITE && sdram_dq_oe)    viol = 4'd9;
                end
                CMD_PRE: begin
                    if (trc_busy) viol = 4'd5;
                end
                CMD_REF: begin
                    if (any_trp)         viol = 4'd4;
                    else if (trc_busy)   viol = 4'd5;
                    else if (any_active) viol = 4'd8;
                end
                default: viol = 4'd0;
            endcase
        end
    end

    assign rd_fire = cmd_en && (cmd == CMD_READ)  && (viol == 4'd0);
    assign wr_fire = cmd_en && (cmd == CMD_WRITE) && (viol == 4'd0);

    // Full {ba,row,col} address truncated to the backing array size.
    assign full_addr = {sdram_ba, bank_row[sdram_ba], sdram_addr[7:0]};
    assign mem_idx   = full_addr[MEM_AW-1:0];

    always_comb begin
        mem_word = mem[mem_idx];
        rd_word  = 32'd0;
        for (int i = 0; i < 4; i++) begin
            rd_word[8*i +: 8] = sdram_dqm[i] ? 8'h00 : mem_word[8*i +: 8];
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (!reset && wr_fire) begin
            for (int i = 0; i < 4; i++) begin
                if (!sdram_dqm[i]) begin
                    mem[mem_idx][8*i +: 8] <= sdram_dq_i[8*i +: 8];
                end
            end
        end
    end

    // Stage 0 holds a read issued at edge T; CAS 2 presents it at T+1, CAS 3 goes one stage deeper.
    assign rd_out = cas3 ? rd_pipe[1] : rd_pipe[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int b = 0; b < 4; b++) begin
                bank_st[b]  <= BANK_IDLE;
                bank_row[b] <= 11'd0;
                trcd_cnt[b] <= 4'd0;
                trp_cnt[b]  <= 4'd0;
            end
            trc_cnt      <= 4'd0;
            cas3         <= 1'b0;
            mode_valid   <= 1'b0;
            protocol_err <= 1'b0;
            err_code     <= 4'd0;
            rd_pipe[0]   <= '0;
            rd_pipe[1]   <= '0;
            sdram_dq_o   <= 32'd0;
            sdram_dq_oe  <= 1'b0;
        end else begin
            // Timers run every cycle; a command below may reload them.
            for (int b = 0; b < 4; b++) begin
                trcd_cnt[b] <= (trcd_cnt[b] != 4'd0) ? trcd_cnt[b] - 4'd1 : 4'd0;
                trp_cnt[b]  <= (trp_cnt[b]  != 4'd0) ? trp_cnt[b]  - 4'd1 : 4'd0;
            end
            trc_cnt <= trc_busy ? trc_cnt - 4'd1 : 4'd0;

            if (viol != 4'd0) begin
                protocol_err <= 1'b1;
                if (!protocol_err) begin
                    err_code <= viol;
                end
            end else if (cmd_en) begin
                case (cmd)
                    CMD_MRS: begin
                        cas3       <= sdram_addr[4];
                        mode_valid <= 1'b1;
                    end
                    CMD_ACT: begin
                        bank_st[sdram_ba]  <= BANK_ACTIVE;
                        bank_row[sdram_ba] <= sdram_addr;
                        trcd_cnt[sdram_ba] <= TRCD_INIT;
                    end
                    CMD_READ, CMD_WRITE: begin
                        if (sdram_addr[10]) begin
                            bank_st[sdram_ba] <= BANK_IDLE;
                            trp_cnt[sdram_ba] <= TRP_INIT;
                        end
                    end
                    CMD_PRE: begin
                        // Precharging an idle bank must not restart its tRP.
                        for (int b = 0; b < 4; b++) begin
                            if ((sdram_addr[10] || 2'(b) == sdram_ba) && bank_st[b] == BANK_ACTIVE) begin
                                bank_st[b] <= BANK_IDLE;
                                trp_cnt[b] <= TRP_INIT;
                            end
                        end
                    end
                    CMD_REF: trc_cnt <= TRC_INIT;
                    default: ;
                endcase
            end

            rd_pipe[0]  <= {rd_fire, rd_word};
            rd_pipe[1]  <= rd_pipe[0];
            sdram_dq_oe <= rd_out.vld;
            sdram_dq_o  <= rd_out.vld ? rd_out.dat : 32'd0;
        end
    end
endmodule
